nfc_acg_arbiter: RTL and testbench

- Shares the single atomic command generator (ACG) port between NumberOfReqs NAND command blocks (get/set feature, reset, read ID, ...).
- Arbitration is round-robin. The grant is locked for the whole multi-step command sequence, until the owner signals its last step.
- Muxes the owner's ACG control/CA fields downstream and routes ACG Ready/LastStep back to the owner only.
- Includes a watchdog that force-releases a hung owner.

---
 rtl/nfc_acg_arbiter.sv | 119 +++++++++++
 tb/tb_nfc_acg_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_acg_arbiter.sv
// nfc_acg_arbiter: round-robin owner lock on the shared ACG port, with CA/control mux,
// ready/last-step routing back to the owner and a watchdog that force-releases hung owners.
module nfc_acg_arbiter #(
  parameter int          NumberOfReqs  = 4,
  parameter int          NumberOfWays  = 4,
  parameter logic [23:0] TimeoutCycles = 24'd1048576
) (
  input  logic                                 iSystemClock,
  input  logic                                 iReset,
  input  logic [NumberOfReqs-1:0]              iReq,
  input  logic [NumberOfReqs-1:0]              iLastStep,
  output logic [NumberOfReqs-1:0]              oGrant,
  output logic                                 oGrantValid,
  output logic                                 oTimeout,
  input  logic [8*NumberOfReqs-1:0]            iReqACG_Command,
  input  logic [3*NumberOfReqs-1:0]            iReqACG_CommandOption,
  input  logic [NumberOfWays*NumberOfReqs-1:0] iReqACG_TargetWay,
  input  logic [16*NumberOfReqs-1:0]           iReqACG_NumOfData,
  input  logic [NumberOfReqs-1:0]              iReqACG_CASelect,
  input  logic [40*NumberOfReqs-1:0]           iReqACG_CAData,
  output logic [8*NumberOfReqs-1:0]            oReqACG_Ready,
  output logic [8*NumberOfReqs-1:0]            oReqACG_LastStep,
  output logic [7:0]                           oACG_Command,
  output logic [2:0]                           oACG_CommandOption,
  output logic [NumberOfWays-1:0]              oACG_TargetWay,
  output logic [15:0]                          oACG_NumOfData,
  output logic                                 oACG_CASelect,
  output logic [39:0]                          oACG_CAData,
  input  logic [7:0]                           iACG_Ready,
  input  logic [7:0]                           iACG_LastStep
);
  localparam int IW = (NumberOfReqs > 1) ? $clog2(NumberOfReqs) : 1;
  typedef enum logic [2:0] {IDLE = 3'b001, BUSY = 3'b010, RELEASE = 3'b100} state_t;
  state_t                  state_q, state_d;
  logic [NumberOfReqs-1:0] grant_q, grant_d;
  logic [IW-1:0]           gidx_q, gidx_d, ptr_q, ptr_d, sel_idx, gidx_inc;
  logic [23:0]             wd_q, wd_d;
  logic                    busy, rel, wd_hit;
  int                      j, g;
  assign busy        = state_q == BUSY;
  assign rel         = iLastStep[gidx_q] | ~iReq[gidx_q];
  assign wd_hit      = (TimeoutCycles != 24'd0) && (wd_q == TimeoutCycles - 24'd1);
  assign gidx_inc    = (gidx_q == IW'(NumberOfReqs - 1)) ? '0 : gidx_q + IW'(1);
  assign g           = int'(gidx_q);
  assign oGrant      = grant_q;
  assign oGrantValid = |grant_q;
  assign oTimeout    = busy & wd_hit & ~rel;
  // Descending scan so the requester closest to the pointer overwrites the rest.
  always_comb begin
    sel_idx = '0;
    j = 0;
    for (int k = NumberOfReqs - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NumberOfReqs;
      if (iReq[IW'(j)]) sel_idx = IW'(j);
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: if (|iReq) begin
        state_d = BUSY;
        grant_d = NumberOfReqs'(1) << sel_idx;
        gidx_d  = sel_idx;
        wd_d    = '0;
      end
      BUSY: begin
        wd_d = (wd_q == '1) ? wd_q : wd_q + 24'd1;
        if (rel || wd_hit) begin
          state_d = RELEASE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = gidx_inc;
      end
    endcase
  end
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end
  always_comb begin
    oACG_Command       = 8'h00;
    oACG_CommandOption = 3'd0;
    oACG_TargetWay     = '0;
    oACG_NumOfData     = 16'd0;
    oACG_CASelect      = 1'b1;
    oACG_CAData        = 40'd0;
    oReqACG_Ready      = '0;
    oReqACG_LastStep   = '0;
    if (busy) begin
      oACG_Command                = iReqACG_Command[8*g +: 8];
      oACG_CommandOption          = iReqACG_CommandOption[3*g +: 3];
      oACG_TargetWay              = iReqACG_TargetWay[NumberOfWays*g +: NumberOfWays];
      oACG_NumOfData              = iReqACG_NumOfData[16*g +: 16];
      oACG_CASelect               = iReqACG_CASelect[gidx_q];
      oACG_CAData                 = iReqACG_CAData[40*g +: 40];
      oReqACG_Ready[8*g +: 8]     = iACG_Ready;
      oReqACG_LastStep[8*g +: 8]  = iACG_LastStep;
    end
  end
endmodule

// File: tb/tb_nfc_acg_arbiter.sv
// tb_nfc_acg_arbiter: directed vector table plus hand sequences for release, timeout and reset.
module tb_nfc_acg_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0, last = '0, grant;
  logic          gvalid, tout;
  logic [8*N-1:0]  cmd_bus, rdy_bus, ls_bus;
  logic [3*N-1:0]  opt_bus;
  logic [W*N-1:0]  way_bus;
  logic [16*N-1:0] nd_bus;
  logic [N-1:0]    cs_bus;
  logic [40*N-1:0] ca_bus;
  logic [7:0]  o_cmd, acg_rdy = '0, acg_ls = '0;
  logic [2:0]  o_opt;
  logic [W-1:0] o_way;
  logic [15:0] o_nd;
  logic        o_cs;
  logic [39:0] o_ca;
  int checks = 0, failures = 0;
  logic [7:0]  cmd_a [N] = '{8'h02, 8'h04, 8'h08, 8'h10};
  logic [2:0]  opt_a [N] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0]  way_a [N] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] nd_a  [N] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  logic        cs_a  [N] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [39:0] ca_a  [N] = '{40'hCC11223344, 40'hDD55667788, 40'hEE00000000, 40'hFF99AABBCC};
  typedef struct {
    logic [3:0]  req;
    logic [7:0]  rdy;
    logic [7:0]  ls;
    logic [3:0]  exp_grant;
    int          exp_idx;
    logic [31:0] exp_rdy;
    logic [31:0] exp_ls;
  } vec_t;
  vec_t tbl [8];

  nfc_acg_arbiter #(.NumberOfReqs(N), .NumberOfWays(W), .TimeoutCycles(24'd16)) dut (
    .iSystemClock(clk), .iReset(rst_n), .iReq(req), .iLastStep(last),
    .oGrant(grant), .oGrantValid(gvalid), .oTimeout(tout),
    .iReqACG_Command(cmd_bus), .iReqACG_CommandOption(opt_bus), .iReqACG_TargetWay(way_bus),
    .iReqACG_NumOfData(nd_bus), .iReqACG_CASelect(cs_bus), .iReqACG_CAData(ca_bus),
    .oReqACG_Ready(rdy_bus), .oReqACG_LastStep(ls_bus),
    .oACG_Command(o_cmd), .oACG_CommandOption(o_opt), .oACG_TargetWay(o_way),
    .oACG_NumOfData(o_nd), .oACG_CASelect(o_cs), .oACG_CAData(o_ca),
    .iACG_Ready(acg_rdy), .iACG_LastStep(acg_ls)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_grant"}, 64'(grant), 64'h0);
    chk({name, "_valid"}, 64'(gvalid), 64'h0);
    chk({name, "_cmd"}, 64'(o_cmd), 64'h0);
    chk({name, "_cs"}, 64'(o_cs), 64'h1);
    chk({name, "_ca"}, 64'(o_ca), 64'h0);
    chk({name, "_rdy"}, 64'(rdy_bus), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cmd_bus[8*i +: 8]   = cmd_a[i];
      opt_bus[3*i +: 3]   = opt_a[i];
      way_bus[W*i +: W]   = way_a[i];
      nd_bus[16*i +: 16]  = nd_a[i];
      cs_bus[i]           = cs_a[i];
      ca_bus[40*i +: 40]  = ca_a[i];
    end
    tbl[0] = '{4'b0100, 8'hFF, 8'h00, 4'b0100, 2, 32'h00FF0000, 32'h00000000};
    tbl[1] = '{4'b0011, 8'hA5, 8'h01, 4'b0001, 0, 32'h000000A5, 32'h00000001};
    tbl[2] = '{4'b0101, 8'h5A, 8'h80, 4'b0100, 2, 32'h005A0000, 32'h00800000};
    tbl[3] = '{4'b1000, 8'h3C, 8'hC3, 4'b1000, 3, 32'h3C000000, 32'hC3000000};
    tbl[4] = '{4'b1010, 8'h11, 8'h22, 4'b0010, 1, 32'h00001100, 32'h00002200};
    tbl[5] = '{4'b1011, 8'h77, 8'h88, 4'b1000, 3, 32'h77000000, 32'h88000000};
    tbl[6] = '{4'b1111, 8'h0F, 8'hF0, 4'b0001, 0, 32'h0000000F, 32'h000000F0};
    tbl[7] = '{4'b1101, 8'h81, 8'h18, 4'b0100, 2, 32'h00810000, 32'h00180000};
    #12;
    chk_idle("reset");
    chk("reset_tout", 64'(tout), 64'h0);
    chk("reset_ls", 64'(ls_bus), 64'h0);
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      req = tbl[v].req;
      acg_rdy = tbl[v].rdy;
      acg_ls = tbl[v].ls;
      tick();
      chk($sformatf("v%0d_grant", v), 64'(grant), 64'(tbl[v].exp_grant));
      chk($sformatf("v%0d_valid", v), 64'(gvalid), 64'h1);
      chk($sformatf("v%0d_cmd", v), 64'(o_cmd), 64'(cmd_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_opt", v), 64'(o_opt), 64'(opt_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_way", v), 64'(o_way), 64'(way_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_nd", v), 64'(o_nd), 64'(nd_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_cs", v), 64'(o_cs), 64'(cs_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_ca", v), 64'(o_ca), 64'(ca_a[tbl[v].exp_idx]));
      chk($sformatf("v%0d_rdy", v), 64'(rdy_bus), 64'(tbl[v].exp_rdy));
      chk($sformatf("v%0d_ls", v), 64'(ls_bus), 64'(tbl[v].exp_ls));
      req = '0;
      acg_rdy = '0;
      acg_ls = '0;
      tick();
      chk_idle($sformatf("v%0d_rel", v));
      tick();
    end
    // Round-robin with iLastStep five cycles into each grant.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      while (!gvalid && n < 10) begin
        n++;
        tick();
      end
      if (k > 0) chk($sformatf("rr%0d_gap", k), 64'(n), 64'd2);
      chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(4'b0001 << (k % 4)));
      repeat (4) tick();
      last = 4'(4'b0001 << (k % 4));
      tick();
      last = '0;
      chk($sformatf("rr%0d_rel", k), 64'(grant), 64'h0);
    end
    req = '0;
    tick();
    tick();
    // Foreign iLastStep is ignored; owner's releases and advances the pointer to 2.
    do_reset();
    req = 4'b0010;
    tick();
    chk("ls_grant", 64'(grant), 64'h2);
    last = 4'b0001;
    tick();
    chk("ls_foreign", 64'(grant), 64'h2);
    last = 4'b0010;
    tick();
    last = '0;
    chk("ls_rel", 64'(grant), 64'h0);
    req = 4'b1111;
    tick();
    tick();
    chk("ls_ptr", 64'(grant), 64'h4);
    req = '0;
    tick();
    tick();
    // Watchdog: owner 0 never finishes.
    do_reset();
    req = 4'b0101;
    tick();
    chk("wd_grant", 64'(grant), 64'h1);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("wd_c%0d", c), 64'(tout), (c == 16) ? 64'h1 : 64'h0);
      if (c < 16) tick();
    end
    tick();
    chk("wd_drop", 64'(grant), 64'h0);
    chk("wd_pulse_end", 64'(tout), 64'h0);
    tick();
    chk("wd_gap", 64'(grant), 64'h0);
    tick();
    chk("wd_next", 64'(grant), 64'h4);
    req = '0;
    tick();
    tick();
    // Timeout coinciding with iLastStep is an ordinary release.
    req = 4'b0001;
    tick();
    repeat (15) tick();
    last = 4'b0001;
    #1;
    chk("wd_ls_tout", 64'(tout), 64'h0);
    tick();
    last = '0;
    req = '0;
    chk("wd_ls_rel", 64'(grant), 64'h0);
    tick();
    // Owner 3 aborts; pointer wraps to 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("ab_grant", 64'(grant), 64'h8);
    chk("ab_cmd", 64'(o_cmd), 64'h10);
    chk("ab_cs", 64'(o_cs), 64'h0);
    req = '0;
    tick();
    chk_idle("ab_rel");
    tick();
    req = 4'b1111;
    tick();
    chk("ab_wrap", 64'(grant), 64'h1);
    req = '0;
    tick();
    tick();
    // Asynchronous reset in the middle of owner 2's command.
    do_reset();
    req = 4'b0101;
    tick();
    req = 4'b0100;
    chk("ar_cmd_pre", 64'(grant), 64'h1);
    tick();
    tick();
    tick();
    chk("ar_owner2", 64'(grant), 64'h4);
    chk("ar_cmd08", 64'(o_cmd), 64'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("ar_async");
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_restart", 64'(grant), 64'h4);
    chk("ar_cmd", 64'(o_cmd), 64'h08);
    req = '0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
